// File: rtl/calc_acc_pipe.sv
// Two-stage pipelined accumulator calculator with valid/ready on both sides.
// Optional build macro CALC_SAT_EN: saturate add/mul overflow, clamp sub underflow.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   command handshake; in_op (3b) and in_data (W) carry the command
//   out_valid/out_ready result handshake; out_data (2W) is the accumulator
//   out_dz, out_ovf     per-result divide-by-zero and overflow/illegal flags
//   op_count (CNT_W)    results produced since reset, wraps silently
module calc_acc_pipe #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_data,
    output logic             out_dz,
    output logic             out_ovf,
    output logic [CNT_W-1:0] op_count
);

    localparam int AW = 2 * W;

    logic           s1_valid;
    logic [2:0]     s1_op;
    logic [W-1:0]   s1_data;
    logic           advance;
    logic           accept;

    logic [AW-1:0]   a;
    logic [AW-1:0]   b;
    logic [AW:0]     sum;
    logic [2*AW-1:0] prod;
    logic            b_zero;

    logic            is_add, is_sub, is_mul, is_div, is_ld;
    logic [AW-1:0]   res;
    logic            res_dz;
    logic            res_ovf;

    // S1 may drain into S2 when S2 is empty or its result leaves this cycle.
    assign advance  = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | advance;
    assign accept   = in_valid & in_ready;

    assign a      = out_data;
    assign b      = {{(AW-W){1'b0}}, s1_data};
    assign sum    = {1'b0, a} + {1'b0, b};
    assign prod   = {{AW{1'b0}}, a} * {{AW{1'b0}}, b};
    assign b_zero = (s1_data == '0);

    assign is_add = (s1_op == 3'b000);
    assign is_sub = (s1_op == 3'b001);
    assign is_mul = (s1_op == 3'b010);
    assign is_div = (s1_op == 3'b011);
    assign is_ld  = (s1_op == 3'b100);

    always_comb begin
        res     = a;
        res_dz  = 1'b0;
        res_ovf = 1'b0;
        unique case (1'b1)
            is_add: begin
                res     = sum[AW-1:0];
                res_ovf = sum[AW];
`ifdef CALC_SAT_EN
                if (sum[AW]) res = '1;
`endif
            end
            is_sub: begin
                res     = a - b;
                res_ovf = (b > a);
`ifdef CALC_SAT_EN
                if (b > a) res = '0;
`endif
            end
            is_mul: begin
                res     = prod[AW-1:0];
                res_ovf = |prod[2*AW-1:AW];
`ifdef CALC_SAT_EN
                if (|prod[2*AW-1:AW]) res = '1;
`endif
            end
            is_div: begin
                if (b_zero) begin
                    res    = '1;
                    res_dz = 1'b1;
                end else begin
                    res = a / b;
                end
            end
            is_ld: begin
                res = b;
            end
            default: begin
                // Illegal opcode: keep the accumulator, report via ovf.
                res_ovf = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_data  <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= in_op;
            s1_data  <= in_data;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dz    <= 1'b0;
            out_ovf   <= 1'b0;
            op_count  <= '0;
        end else if (advance) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_dz    <= res_dz;
            out_ovf   <= res_ovf;
            op_count  <= op_count + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_calc_acc_pipe.sv
// Self-checking bench for calc_acc_pipe (W=8; CNT_W=16 and a CNT_W=2 copy).
// Results are compared with a plain-arithmetic reference model.
module tb_calc_acc_pipe;

    localparam int    W    = 8;
    localparam longint MAXV = 65535;
`ifdef CALC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_op;
    logic [W-1:0] in_data;
    logic        out_ready;

    logic        in_ready, out_valid, out_dz, out_ovf;
    logic [15:0] out_data, op_count;
    logic        in_ready2, out_valid2, out_dz2, out_ovf2;
    logic [15:0] out_data2;
    logic [1:0]  op_count2;

    int checks = 0;
    int errors = 0;

    int          c_op[$];
    int          c_dat[$];
    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];
    int          obs_cyc[$];
    logic        snap_rdy[$];
    logic        snap_vld[$];
    logic [15:0] snap_dat[$];
    longint      m_acc;
    int          m_cnt;

    calc_acc_pipe #(.W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_dz(out_dz), .out_ovf(out_ovf),
        .op_count(op_count)
    );

    calc_acc_pipe #(.W(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_op(in_op), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_dz(out_dz2), .out_ovf(out_ovf2),
        .op_count(op_count2)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Reference: returns {dz, ovf, result[15:0]}.
    function automatic logic [17:0] model(input longint a, input int op,
                                          input longint b);
        longint r;
        logic   dz;
        logic   ovf;
        dz  = 1'b0;
        ovf = 1'b0;
        r   = a;
        case (op)
            0: begin
                r = a + b;
                if (r > MAXV) begin
                    ovf = 1'b1;
                    r   = SAT ? MAXV : r - (MAXV + 1);
                end
            end
            1: begin
                if (b > a) begin
                    ovf = 1'b1;
                    r   = SAT ? 0 : a - b + MAXV + 1;
                end else r = a - b;
            end
            2: begin
                r = a * b;
                if (r > MAXV) begin
                    ovf = 1'b1;
                    r   = SAT ? MAXV : r % (MAXV + 1);
                end
            end
            3: begin
                if (b == 0) begin
                    r  = MAXV;
                    dz = 1'b1;
                end else r = a / b;
            end
            4: r = b;
            default: ovf = 1'b1;
        endcase
        return {dz, ovf, r[15:0]};
    endfunction

    task automatic add_cmd(input int op, input int dat);
        c_op.push_back(op);
        c_dat.push_back(dat);
    endtask

    task automatic build_exp();
        logic [17:0] e;
        exp_q.delete();
        foreach (c_op[i]) begin
            e = model(m_acc, c_op[i], c_dat[i]);
            m_acc = e[15:0];
            m_cnt++;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        m_acc = 0;
        m_cnt = 0;
        c_op.delete();
        c_dat.delete();
    endtask

    // mode 0: out_ready=1; 1: out_ready=0 for cycles 0..3; 2: random gaps.
    task automatic run_cmds(input int mode, input int max_cyc);
        int idx;
        int n;
        idx = 0;
        n   = c_op.size();
        obs_q.delete();
        obs_cyc.delete();
        snap_rdy.delete();
        snap_vld.delete();
        snap_dat.delete();
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(posedge clk);
            #1;
            in_valid = (idx < n);
            if (mode == 2 && $urandom_range(0, 3) == 0) in_valid = 1'b0;
            if (idx < n) begin
                in_op   = 3'(c_op[idx]);
                in_data = 8'(c_dat[idx]);
            end
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) out_ready = (cyc >= 4);
            else out_ready = ($urandom_range(0, 2) != 0);
            #1;
            snap_rdy.push_back(in_ready);
            snap_vld.push_back(out_valid);
            snap_dat.push_back(out_data);
            if (out_valid && out_ready) begin
                obs_q.push_back({out_dz, out_ovf, out_data});
                obs_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) idx++;
            if (idx == n && obs_q.size() == n) break;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        c_op.delete();
        c_dat.delete();
    endtask

    task automatic test_reset();
        checks++;
        if ({out_valid, out_data, out_dz, out_ovf, op_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h dz=%b ovf=%b cnt=%h want all 0",
                     out_valid, out_data, out_dz, out_ovf, op_count);
        end
        checks++;
        if (in_ready !== 1'b1 || op_count2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_ready got rdy=%b cnt2=%0d want rdy=1 cnt2=0",
                     in_ready, op_count2);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        add_cmd(4, 5);
        add_cmd(0, 3);
        add_cmd(1, 2);
        build_exp();
        run_cmds(0, 30);
        checks++;
        if (obs_q.size() !== 3) begin
            errors++;
            $display("FAIL b2b_count got %0d want 3", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 3; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_cyc[i] !== 2 + i) begin
                errors++;
                $display("FAIL b2b_result[%0d] got %h@%0d want %h@%0d",
                         i, obs_q[i], obs_cyc[i], exp_q[i], 2 + i);
            end
        end
        checks++;
        if (op_count !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL b2b_opcount got %0d want %0d", op_count, m_cnt);
        end
    endtask

    task automatic test_mul_ovf();
        do_reset();
        add_cmd(4, 200);
        add_cmd(2, 200);
        add_cmd(2, 2);
        build_exp();
        run_cmds(0, 30);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL mul_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL mul_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_div();
        do_reset();
        add_cmd(4, 7);
        add_cmd(3, 0);
        add_cmd(3, 3);
        build_exp();
        run_cmds(0, 30);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL div_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL div_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] first;
        do_reset();
        add_cmd(4, 11);
        add_cmd(0, 22);
        add_cmd(2, 3);
        build_exp();
        first = exp_q[0][15:0];
        run_cmds(1, 40);
        for (int c = 2; c < 4 && c < snap_rdy.size(); c++) begin
            checks++;
            if (snap_rdy[c] !== 1'b0 || snap_vld[c] !== 1'b1 || snap_dat[c] !== first) begin
                errors++;
                $display("FAIL bp_hold[%0d] got rdy=%b v=%b d=%h want rdy=0 v=1 d=%h",
                         c, snap_rdy[c], snap_vld[c], snap_dat[c], first);
            end
        end
        checks++;
        if (obs_q.size() !== 3) begin
            errors++;
            $display("FAIL bp_count got %0d want 3", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 3; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_sub_illegal();
        do_reset();
        add_cmd(1, 1);
        add_cmd(6, 9);
        add_cmd(4, 40);
        add_cmd(7, 0);
        build_exp();
        run_cmds(0, 30);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL subill_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL subill_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (op_count !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL subill_opcount got %0d want %0d", op_count, m_cnt);
        end
    endtask

    task automatic test_persist();
        do_reset();
        add_cmd(4, 10);
        build_exp();
        run_cmds(0, 20);
        repeat (5) @(posedge clk);
        add_cmd(0, 1);
        build_exp();
        run_cmds(0, 20);
        checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL persist got n=%0d %h want %h", obs_q.size(),
                     obs_q.size() ? obs_q[0] : 18'h0, exp_q[0]);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_op     = 3'd4;
        in_data   = 8'd9;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_op   = 3'd0;
        in_data = 8'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_full got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_dz, out_ovf, op_count, op_count2} !== '0
            || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_clear got v=%b d=%h cnt=%0d rdy=%b want 0/0/0/1",
                     out_valid, out_data, op_count, in_ready);
        end
        @(negedge clk) rst = 1'b1;
        out_ready = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || op_count !== 16'd0) begin
            errors++;
            $display("FAIL midrst_replay got v=%b cnt=%0d want v=0 cnt=0", out_valid, op_count);
        end
        out_ready = 1'b1;
        add_cmd(0, 4);
        build_exp();
        run_cmds(0, 20);
        checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL midrst_acc got n=%0d %h want %h", obs_q.size(),
                     obs_q.size() ? obs_q[0] : 18'h0, exp_q[0]);
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) add_cmd(4, i + 1);
        build_exp();
        run_cmds(0, 30);
        checks++;
        if (op_count2 !== 2'(m_cnt) || op_count !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL wrap_3 got cnt2=%0d cnt=%0d want %0d", op_count2, op_count, m_cnt);
        end
        add_cmd(0, 1);
        add_cmd(0, 1);
        build_exp();
        run_cmds(0, 30);
        checks++;
        if (op_count2 !== 2'(m_cnt) || op_count !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL wrap_5 got cnt2=%0d cnt=%0d want cnt2=%0d cnt=%0d",
                     op_count2, op_count, 2'(m_cnt), m_cnt);
        end
    endtask

    task automatic test_random();
        int o;
        int d;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            o = $urandom_range(0, 9);
            if (o > 7) o = 4;
            d = $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) d = 0;
            add_cmd(o, d);
        end
        build_exp();
        run_cmds(2, 2000);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (op_count !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL rand_opcount got %0d want %0d", op_count, m_cnt);
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_data   = '0;
        out_ready = 1'b1;
        m_acc     = 0;
        m_cnt     = 0;
        #2;
        test_reset();
        test_back_to_back();
        test_mul_ovf();
        test_div();
        test_backpressure();
        test_sub_illegal();
        test_persist();
        test_reset_midflight();
        test_count_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
